// File: rtl/hb_seq_pkg.sv
// Shared encodings for the H-bridge startup sequencer: FSM states, fixed gate
// patterns, fault-code bit positions and the common counter width.
package hb_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BOOT  = 3'd1,
        ST_FORCE = 3'd2,
        ST_RUN   = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    // Gate order is {Q4,Q3,Q2,Q1}
    localparam logic [3:0] GATES_OFF   = 4'b0000;
    localparam logic [3:0] GATES_BOOT  = 4'b1100;
    localparam logic [3:0] GATES_FORCE = 4'b1001;

    localparam int FC_SHOOT_BIT  = 0;
    localparam int FC_ADC_OR_BIT = 1;

    localparam int CNT_W = 20;

    // A leg is shorted when both of its switches (Q1/Q3 or Q2/Q4) are on
    function automatic logic is_shoot_through(input logic [3:0] gates);
        return (gates[0] & gates[2]) | (gates[1] & gates[3]);
    endfunction

endpackage

// File: rtl/or_persistence_filter.sv
// Trips once the ADC out-of-range flag has been high for N consecutive
// enabled clocks; a single low cycle or a disable restarts the count.
module or_persistence_filter
    import hb_seq_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic flag,
    input  logic enable,
    output logic trip
);

    localparam logic [CNT_W-1:0] TRIP_AT = CNT_W'(N - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (!enable || !flag) begin
            r_count <= '0;
        end else if (r_count != '1) begin
            r_count <= r_count + 1'b1;
        end
    end

    // r_count holds the earlier high cycles, so the Nth one trips directly
    assign trip = enable && flag && (r_count >= TRIP_AT);

endmodule

// File: rtl/bridge_startup_sequencer.sv
// Startup/fault sequencer for the full-bridge gate drive: bootstrap charge,
// forced sigma=1, then pass-through of the control law, with latched faults.
module bridge_startup_sequencer
    import hb_seq_pkg::*;
#(
    parameter int unsigned BOOT_CYCLES  = 1000,
    parameter int unsigned FORCE_CYCLES = 1600,
    parameter int unsigned OR_FILTER    = 4,
    parameter int unsigned FAULT_HOLD   = 100000
) (
    input  logic       i_clock,
    input  logic       i_RESET,
    input  logic       i_enable,
    input  logic [3:0] i_MOSFET,
    input  logic [1:0] i_adc_or,
    input  logic       i_fault_clear,
    output logic [3:0] o_MOSFET,
    output logic [2:0] o_state,
    output logic       o_on,
    output logic       o_fault,
    output logic [1:0] o_fault_code
);

    localparam logic [CNT_W-1:0] BOOT_LAST  = CNT_W'(BOOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] FORCE_LAST = CNT_W'(FORCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_AT    = CNT_W'(FAULT_HOLD);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;
    logic [3:0]       r_mosfet;
    logic [3:0]       w_mosfet;
    logic [1:0]       r_code;
    logic [1:0]       w_code;
    logic             r_on;
    logic             r_fault;
    logic             w_active;
    logic             w_shoot;
    logic             w_or_trip;

    assign w_active = (r_state == ST_BOOT) || (r_state == ST_FORCE) || (r_state == ST_RUN);
    assign w_shoot  = (r_state == ST_RUN) && is_shoot_through(i_MOSFET);

    or_persistence_filter #(
        .N(OR_FILTER)
    ) u_or_filter (
        .clock  (i_clock),
        .reset  (i_RESET),
        .flag   (|i_adc_or),
        .enable (w_active),
        .trip   (w_or_trip)
    );

    // Fault sources are checked before the enable drop so they win on a tie
    always_comb begin
        w_next = r_state;
        w_code = r_code;
        if (w_shoot || w_or_trip) begin
            w_next                = ST_FAULT;
            w_code                = '0;
            w_code[FC_SHOOT_BIT]  = w_shoot;
            w_code[FC_ADC_OR_BIT] = w_or_trip;
        end else if (w_active && !i_enable) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (i_enable) w_next = ST_BOOT;
                ST_BOOT:  if (r_count == BOOT_LAST) w_next = ST_FORCE;
                ST_FORCE: if (r_count == FORCE_LAST) w_next = ST_RUN;
                ST_FAULT: begin
                    if ((r_count >= HOLD_AT) && i_fault_clear && !i_enable) begin
                        w_next = ST_IDLE;
                        w_code = '0;
                    end
                end
                default:  w_next = r_state;
            endcase
        end
    end

    // Gate pattern follows the upcoming state so o_MOSFET stays registered
    always_comb begin
        w_mosfet = GATES_OFF;
        case (w_next)
            ST_BOOT:  w_mosfet = GATES_BOOT;
            ST_FORCE: w_mosfet = GATES_FORCE;
            ST_RUN:   w_mosfet = is_shoot_through(i_MOSFET) ? GATES_OFF : i_MOSFET;
            default:  w_mosfet = GATES_OFF;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_RESET) begin
        if (i_RESET) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_mosfet <= GATES_OFF;
            r_code   <= '0;
            r_on     <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_mosfet <= w_mosfet;
            r_code   <= w_code;
            r_on     <= (w_next == ST_RUN);
            r_fault  <= (w_next == ST_FAULT);
            if (w_next != r_state) begin
                r_count <= '0;
            end else if (r_count != '1) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_state      = r_state;
    assign o_MOSFET     = r_mosfet;
    assign o_on         = r_on;
    assign o_fault      = r_fault;
    assign o_fault_code = r_code;

endmodule

// File: tb/tb_bridge_startup_sequencer.sv
// Scoreboard bench for bridge_startup_sequencer: a phase-timeline model predicts
// each clock's outputs into a queue that a free-running monitor drains.
module tb_bridge_startup_sequencer;

    localparam int BOOT_N  = 20;
    localparam int FORCE_N = 30;
    localparam int OR_N    = 4;
    localparam int HOLD_N  = 200;

    localparam int M_IDLE  = 0;
    localparam int M_BOOT  = 1;
    localparam int M_FORCE = 2;
    localparam int M_RUN   = 3;
    localparam int M_FAULT = 4;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] mos;
        logic       on;
        logic       flt;
        logic [1:0] code;
    } obs_t;

    logic       clk = 1'b0;
    logic       i_RESET = 1'b1;
    logic       i_enable = 1'b0;
    logic [3:0] i_MOSFET = 4'b0000;
    logic [1:0] i_adc_or = 2'b00;
    logic       i_fault_clear = 1'b0;
    logic [3:0] o_MOSFET;
    logic [2:0] o_state;
    logic       o_on;
    logic       o_fault;
    logic [1:0] o_fault_code;

    obs_t expQ[$];
    int   nChecks = 0;
    int   nFails  = 0;

    int         mMode  = M_IDLE;
    int         mSince = 0;
    int         mAge   = 0;
    int         mOrRun = 0;
    logic [1:0] mCode  = 2'b00;
    logic [3:0] mMos   = 4'b0000;

    bridge_startup_sequencer #(
        .BOOT_CYCLES  (BOOT_N),
        .FORCE_CYCLES (FORCE_N),
        .OR_FILTER    (OR_N),
        .FAULT_HOLD   (HOLD_N)
    ) dut (
        .i_clock       (clk),
        .i_RESET       (i_RESET),
        .i_enable      (i_enable),
        .i_MOSFET      (i_MOSFET),
        .i_adc_or      (i_adc_or),
        .i_fault_clear (i_fault_clear),
        .o_MOSFET      (o_MOSFET),
        .o_state       (o_state),
        .o_on          (o_on),
        .o_fault       (o_fault),
        .o_fault_code  (o_fault_code)
    );

    always #5 clk = ~clk;

    function automatic logic illegal(input logic [3:0] g);
        return (g[0] && g[2]) || (g[1] && g[3]);
    endfunction

    function automatic logic [3:0] randLegal();
        logic [3:0] g;
        g = 4'(($urandom_range(0, 15)));
        while (illegal(g)) g = 4'(($urandom_range(0, 15)));
        return g;
    endfunction

    // Position on the enable timeline decides the phase, not a per-state counter
    function automatic int phaseOf(input int since);
        if (since < BOOT_N) return M_BOOT;
        if (since < BOOT_N + FORCE_N) return M_FORCE;
        return M_RUN;
    endfunction

    function automatic obs_t expected();
        obs_t e;
        e.st   = 3'(mMode);
        e.mos  = mMos;
        e.on   = (mMode == M_RUN);
        e.flt  = (mMode == M_FAULT);
        e.code = mCode;
        return e;
    endfunction

    task automatic modelStep(input logic en, input logic [3:0] mos, input logic [1:0] adc,
                             input logic clr, input logic rst);
        logic active;
        logic shoot;
        logic trip;
        if (rst) begin
            mMode = M_IDLE; mSince = 0; mAge = 0; mOrRun = 0; mCode = 2'b00; mMos = 4'b0000;
            return;
        end
        active = (mMode == M_BOOT) || (mMode == M_FORCE) || (mMode == M_RUN);
        shoot  = (mMode == M_RUN) && illegal(mos);
        mOrRun = (active && (adc != 2'b00)) ? mOrRun + 1 : 0;
        trip   = (mOrRun >= OR_N);
        if (shoot || trip) begin
            mMode = M_FAULT; mAge = 0; mCode = {trip, shoot};
        end else if (active && !en) begin
            mMode = M_IDLE;
        end else if (mMode == M_IDLE) begin
            if (en) begin
                mMode = M_BOOT; mSince = 0;
            end
        end else if (mMode == M_FAULT) begin
            mAge++;
            if (mAge > HOLD_N && clr && !en) begin
                mMode = M_IDLE; mCode = 2'b00;
            end
        end else begin
            if (mSince < BOOT_N + FORCE_N) mSince++;
            mMode = phaseOf(mSince);
        end
        case (mMode)
            M_BOOT:  mMos = 4'b1100;
            M_FORCE: mMos = 4'b1001;
            M_RUN:   mMos = illegal(mos) ? 4'b0000 : mos;
            default: mMos = 4'b0000;
        endcase
    endtask

    task automatic applyStimulus(input logic en, input logic [3:0] mos, input logic [1:0] adc,
                                 input logic clr, input logic rst);
        @(negedge clk);
        i_RESET       = rst;
        i_enable      = en;
        i_MOSFET      = mos;
        i_adc_or      = adc;
        i_fault_clear = clr;
        modelStep(en, mos, adc, clr, rst);
        expQ.push_back(expected());
    endtask

    task automatic checkOutput(input string name, input obs_t exp);
        obs_t act;
        act.st   = o_state;
        act.mos  = o_MOSFET;
        act.on   = o_on;
        act.flt  = o_fault;
        act.code = o_fault_code;
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s t=%0t actual st=%0d mos=%b on=%b flt=%b code=%b required st=%0d mos=%b on=%b flt=%b code=%b",
                     name, $time, act.st, act.mos, act.on, act.flt, act.code,
                     exp.st, exp.mos, exp.on, exp.flt, exp.code);
        end
    endtask

    task automatic runNormal(input int n, input logic en);
        for (int k = 0; k < n; k++) applyStimulus(en, randLegal(), 2'b00, 1'b0, 1'b0);
    endtask

    task automatic holdFault(input int n, input logic en);
        for (int k = 0; k < n; k++) applyStimulus(en, randLegal(), 2'b00, 1'b1, 1'b0);
    endtask

    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("cycle", e);
            end
        end
    end

    initial begin
        obs_t zero;
        zero = '0;
        $display("[TB] start");

        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 4'b0000, 2'b00, 1'b0, 1'b1);
        runNormal(5, 1'b0);

        // Startup to RUN, shoot-through fault, then clear attempts with enable high/low
        runNormal(BOOT_N + FORCE_N + 10, 1'b1);
        applyStimulus(1'b1, 4'b0101, 2'b00, 1'b0, 1'b0);
        holdFault(HOLD_N + 20, 1'b1);
        holdFault(4, 1'b0);

        // Out-of-range burst of 3 is filtered, burst of 4 trips
        runNormal(BOOT_N + FORCE_N + 5, 1'b1);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, randLegal(), 2'b01, 1'b0, 1'b0);
        applyStimulus(1'b1, randLegal(), 2'b00, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) applyStimulus(1'b1, randLegal(), 2'b01, 1'b0, 1'b0);
        holdFault(HOLD_N + 5, 1'b0);

        // Enable drop mid-BOOT, full restart, async reset inside FORCE
        runNormal(BOOT_N / 2, 1'b1);
        runNormal(3, 1'b0);
        runNormal(BOOT_N + 10, 1'b1);
        @(posedge clk);
        #3;
        i_RESET = 1'b1;
        #1;
        checkOutput("async_reset", zero);
        applyStimulus(1'b1, randLegal(), 2'b00, 1'b0, 1'b1);
        runNormal(4, 1'b0);

        // Shoot-through and 4th out-of-range cycle together while enable drops
        runNormal(BOOT_N + FORCE_N + 5, 1'b1);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, randLegal(), 2'b10, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b1010, 2'b10, 1'b0, 1'b0);
        holdFault(HOLD_N + 5, 1'b0);

        for (int k = 0; k < 3000; k++) begin
            logic       en;
            logic [3:0] mos;
            logic [1:0] adc;
            en  = ($urandom_range(0, 99) < 97);
            mos = ($urandom_range(0, 99) < 2) ? 4'($urandom_range(0, 15)) : randLegal();
            adc = ($urandom_range(0, 99) < 20) ? 2'($urandom_range(1, 3)) : 2'b00;
            applyStimulus(en, mos, adc, 1'($urandom_range(0, 1)), ($urandom_range(0, 999) == 0));
        end

        repeat (3) @(posedge clk);
        #2;
        nChecks++;
        if (expQ.size() != 0) begin
            nFails++;
            $display("[TB] FAIL queue_drain actual %0d pending required 0", expQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
